spi_master_ctrl: RTL and testbench

SPI initiator that drives the SS_n/MOSI/MISO serial link of the team's SPI RAM slave from a parallel request interface. One accepted request produces one complete frame: select, a command-check bit, a 10-bit word of {cmd[1:0], data[7:0]}, and for read-data commands an 8-bit response captured from MISO. Sits between a system-side controller (CPU/test sequencer) and the SPI RAM slave; both run on the same clk, one serial bit per clk cycle.

---
 rtl/spi_master_ctrl.sv | 77 +++++++
 tb/tb_spi_master_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: parallel-request SPI initiator producing one select/check/10-bit/optional 8-bit-response frame per request.
module spi_master_ctrl #(
  parameter int unsigned MISO_LAT = 2,
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);
  typedef enum logic [2:0] {S_IDLE, S_SEL, S_CHK, S_SHIFT, S_WAIT, S_RECV, S_END, S_GAP} state_e;
  localparam logic [3:0] LAT_LAST = 4'(MISO_LAT - 2);
  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 2);
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  sh_q, sh_d;
  logic        rd_q, rd_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        accept;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      rd_q      <= 1'b0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rd_q      <= rd_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_SEL : S_IDLE;
      S_SEL:   state_d = S_CHK;
      S_CHK:   state_d = S_SHIFT;
      S_SHIFT: state_d = (cnt_q != 4'd9) ? S_SHIFT : !rd_q ? S_END : (MISO_LAT == 1) ? S_RECV : S_WAIT;
      S_WAIT:  state_d = (cnt_q == LAT_LAST) ? S_RECV : S_WAIT;
      S_RECV:  state_d = (cnt_q == 4'd7) ? S_END : S_RECV;
      S_END:   state_d = (IDLE_GAP == 1) ? S_IDLE : S_GAP;
      S_GAP:   state_d = (cnt_q == GAP_LAST) ? S_IDLE : S_GAP;
      default: state_d = S_IDLE;
    endcase
  end
  // Every state's counter restarts at 0 on entry; the final RECV bit goes straight into rx_data so it is valid during END.
  always_comb begin
    accept    = (state_q == S_IDLE) && start;
    cnt_d     = (state_d != state_q || state_q == S_IDLE) ? 4'd0 : cnt_q + 4'd1;
    sh_d      = accept ? {cmd, tx_data} : (state_q == S_SHIFT) ? {sh_q[8:0], 1'b0} : sh_q;
    rd_d      = accept ? &cmd : rd_q;
    rx_sh_d   = (state_q == S_RECV) ? {rx_sh_q[6:0], MISO} : rx_sh_q;
    rx_data_d = (state_q == S_RECV && cnt_q == 4'd7) ? {rx_sh_q[6:0], MISO} : rx_data_q;
  end
  always_comb begin
    SS_n     = (state_q == S_IDLE) || (state_q == S_END) || (state_q == S_GAP);
    MOSI     = ((state_q == S_CHK) || (state_q == S_SHIFT)) ? sh_q[9] : 1'b0;
    busy     = state_q != S_IDLE;
    done     = state_q == S_END;
    rx_valid = (state_q == S_END) && rd_q;
    rx_data  = rx_data_q;
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: scoreboard bench for spi_master_ctrl across three parameter sets.
module tb_spi_master_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_s [3];
  logic [1:0] cmd_s   [3];
  logic [7:0] txd_s   [3];
  logic       miso_s  [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic [7:0] rxd_w   [3];
  logic       rxv_w   [3];
  logic       ss_w    [3];
  logic       mosi_w  [3];
  int lat_a [3] = '{2, 1, 4};
  int gap_a [3] = '{1, 3, 3};
  logic [7:0] last_rx [3] = '{8'h00, 8'h00, 8'h00};
  logic exp_q [$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_master_ctrl u0 (.clk(clk), .rst(rst), .start(start_s[0]), .cmd(cmd_s[0]), .tx_data(txd_s[0]),
    .busy(busy_w[0]), .done(done_w[0]), .rx_data(rxd_w[0]), .rx_valid(rxv_w[0]),
    .SS_n(ss_w[0]), .MOSI(mosi_w[0]), .MISO(miso_s[0]));
  spi_master_ctrl #(.MISO_LAT(1), .IDLE_GAP(3)) u1 (.clk(clk), .rst(rst), .start(start_s[1]), .cmd(cmd_s[1]),
    .tx_data(txd_s[1]), .busy(busy_w[1]), .done(done_w[1]), .rx_data(rxd_w[1]), .rx_valid(rxv_w[1]),
    .SS_n(ss_w[1]), .MOSI(mosi_w[1]), .MISO(miso_s[1]));
  spi_master_ctrl #(.MISO_LAT(4), .IDLE_GAP(3)) u2 (.clk(clk), .rst(rst), .start(start_s[2]), .cmd(cmd_s[2]),
    .tx_data(txd_s[2]), .busy(busy_w[2]), .done(done_w[2]), .rx_data(rxd_w[2]), .rx_valid(rxv_w[2]),
    .SS_n(ss_w[2]), .MOSI(mosi_w[2]), .MISO(miso_s[2]));

  task automatic wait_idle(input int u);
    for (int i = 0; i < 100 && busy_w[u] !== 1'b0; i++) @(negedge clk);
    n_chk++;
    if (busy_w[u] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout u%0d: busy=%b want 0", u, busy_w[u]);
    end
  endtask

  task automatic do_frame(input int u, input logic [1:0] c, input logic [7:0] d, input logic [7:0] mb,
                          input bit inj, input bit hold);
    int lat, len, lo, dk, vk;
    bit rd;
    logic [9:0] w;
    logic e;
    logic [7:0] rx_exp;
    lat = lat_a[u];
    rd = (c == 2'b11);
    len = rd ? 19 + lat : 12;
    lo = 0; dk = 0; vk = 0;
    w = {c, d};
    wait_idle(u);
    exp_q = {};
    exp_q.push_back(1'b0);
    exp_q.push_back(c[1]);
    for (int i = 9; i >= 0; i--) exp_q.push_back(w[i]);
    if (rd) for (int i = 0; i < lat + 7; i++) exp_q.push_back(1'b0);
    start_s[u] = 1'b1; cmd_s[u] = c; txd_s[u] = d;
    @(posedge clk);
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_s[u] = hold;
        if (!hold) begin cmd_s[u] = ~c; txd_s[u] = ~d; end
      end
      if (inj && k == 3) begin start_s[u] = 1'b1; cmd_s[u] = c ^ 2'b01; end
      if (inj && k == 4) start_s[u] = 1'b0;
      miso_s[u] = (rd && k >= 12 + lat && k < 20 + lat) ? mb[19 + lat - k] : 1'b0;
      if (ss_w[u] === 1'b0) begin
        lo++;
        e = (exp_q.size() == 0) ? 1'bx : exp_q.pop_front();
        n_chk++;
        if (mosi_w[u] !== e) begin
          n_fail++;
          $display("FAIL mosi u%0d cmd=%b data=%h cycle %0d: got %b want %b", u, c, d, k, mosi_w[u], e);
        end
      end
      if (done_w[u] === 1'b1 && dk == 0) dk = k;
      if (rxv_w[u] === 1'b1 && vk == 0) vk = k;
    end
    rx_exp = rd ? mb : last_rx[u];
    n_chk++;
    if (lo != len) begin n_fail++; $display("FAIL ss_low_len u%0d cmd=%b: got %0d want %0d", u, c, lo, len); end
    n_chk++;
    if (dk != len + 1) begin n_fail++; $display("FAIL done_latency u%0d cmd=%b: got %0d want %0d", u, c, dk, len + 1); end
    n_chk++;
    if (vk != (rd ? len + 1 : 0)) begin
      n_fail++; $display("FAIL rx_valid_cycle u%0d cmd=%b: got %0d want %0d", u, c, vk, rd ? len + 1 : 0);
    end
    n_chk++;
    if (rxd_w[u] !== rx_exp) begin n_fail++; $display("FAIL rx_data u%0d cmd=%b: got %h want %h", u, c, rxd_w[u], rx_exp); end
    last_rx[u] = rx_exp;
    @(negedge clk);
    n_chk++;
    if ({done_w[u], rxv_w[u], ss_w[u]} !== 3'b001) begin
      n_fail++; $display("FAIL post_end u%0d: done/rxv/ss got %b%b%b want 001", u, done_w[u], rxv_w[u], ss_w[u]);
    end
  endtask

  task automatic measure_gap(input int u);
    int hi;
    hi = 2;
    for (int i = 0; i < 40 && ss_w[u] === 1'b1; i++) begin
      @(negedge clk);
      if (ss_w[u] === 1'b1) hi++;
    end
    start_s[u] = 1'b0;
    n_chk++;
    if (hi != gap_a[u] + 1) begin n_fail++; $display("FAIL ss_high_gap u%0d: got %0d want %0d", u, hi, gap_a[u] + 1); end
    wait_idle(u);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      n_chk++;
      if ({ss_w[u], mosi_w[u], busy_w[u], done_w[u], rxv_w[u], rxd_w[u]} !== {5'b10000, 8'h00}) begin
        n_fail++;
        $display("FAIL reset_state u%0d: ss/mosi/busy/done/rxv/rxd got %b%b%b%b%b/%h want 10000/00", u,
                 ss_w[u], mosi_w[u], busy_w[u], done_w[u], rxv_w[u], rxd_w[u]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write;
    do_frame(0, 2'b00, 8'hD9, 8'h00, 1'b0, 1'b0);
    do_frame(0, 2'b01, 8'h59, 8'h00, 1'b0, 1'b0);
    do_frame(0, 2'b10, 8'hD9, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_read_data;
    do_frame(0, 2'b11, 8'h00, 8'hA5, 1'b0, 1'b0);
    do_frame(0, 2'b00, 8'h12, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    do_frame(0, 2'b00, 8'h3C, 8'h00, 1'b1, 1'b0);
    do_frame(0, 2'b01, 8'h96, 8'h00, 1'b0, 1'b1);
    measure_gap(0);
  endtask

  task automatic test_mid_reset;
    int bad;
    bad = 0;
    wait_idle(0);
    start_s[0] = 1'b1; cmd_s[0] = 2'b11; txd_s[0] = 8'h55;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) start_s[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({ss_w[0], busy_w[0], done_w[0], rxv_w[0], rxd_w[0]} !== {4'b1000, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_reset u0: ss/busy/done/rxv/rxd got %b%b%b%b/%h want 1000/00",
               ss_w[0], busy_w[0], done_w[0], rxv_w[0], rxd_w[0]);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) last_rx[i] = 8'h00;
    repeat (25) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0 || rxv_w[0] !== 1'b0 || ss_w[0] !== 1'b1) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL after_reset_quiet u0: got %0d bad cycles want 0", bad); end
    do_frame(0, 2'b00, 8'hD9, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_sweep;
    do_frame(1, 2'b10, 8'h4E, 8'h00, 1'b0, 1'b0);
    do_frame(1, 2'b11, 8'h00, 8'h3C, 1'b0, 1'b0);
    do_frame(2, 2'b10, 8'hB1, 8'h00, 1'b0, 1'b0);
    do_frame(2, 2'b11, 8'h00, 8'hC3, 1'b0, 1'b0);
    do_frame(1, 2'b01, 8'h81, 8'h00, 1'b0, 1'b1);
    measure_gap(1);
    do_frame(2, 2'b11, 8'h00, 8'h69, 1'b0, 1'b1);
    measure_gap(2);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; cmd_s[i] = 2'b00; txd_s[i] = 8'h00; miso_s[i] = 1'b0;
    end
    test_reset;
    test_write;
    test_read_data;
    test_back_to_back;
    test_mid_reset;
    test_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
